// File: rtl/lif_neuron_scheduler.sv
// lif_neuron_scheduler: time-multiplexed leaky integrate-and-fire update of NUM_NEURONS membranes
// with one shared datapath, one-cycle-latency current fetch and a valid/ready spike stream.
module lif_neuron_scheduler #(
  parameter int                 NUM_NEURONS = 8,
  parameter int                 ADDR_W      = 3,
  parameter int                 LEAK_SHIFT  = 3,
  parameter logic signed [15:0] THRESHOLD   = 16'sd100,
  parameter logic signed [15:0] V_RESET     = 16'sd0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     step_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     cur_rd_o,
  output logic [ADDR_W-1:0]        cur_addr_o,
  input  logic signed [15:0]       cur_data_i,
  output logic                     spike_valid_o,
  input  logic                     spike_ready_i,
  output logic [ADDR_W-1:0]        spike_id_o,
  output logic [ADDR_W:0]          spike_count_o,
  input  logic [ADDR_W-1:0]        dbg_addr_i,
  output logic signed [15:0]       dbg_v_o
);
  typedef enum logic [2:0] {IDLE, FETCH, UPDATE, EMIT, DONE} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d, spike_id_q, spike_id_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic signed [15:0]  v_q [NUM_NEURONS];
  logic signed [15:0]  v_cur, sat, v_wd;
  logic signed [17:0]  v_ext, c_ext, s;
  logic                v_we, fire, adv, last;
  assign v_cur = v_q[idx_q];
  assign v_ext = {{2{v_cur[15]}}, v_cur};
  assign c_ext = {{2{cur_data_i[15]}}, cur_data_i};
  // 18 bits hold v - leak + current without overflow, so clamping afterwards is exact
  assign s     = v_ext - (v_ext >>> LEAK_SHIFT) + c_ext;
  assign sat   = s > 18'sd32767 ? 16'sh7fff : s < -18'sd32768 ? 16'sh8000 : s[15:0];
  assign fire  = sat >= THRESHOLD;
  assign last  = idx_q == ADDR_W'(NUM_NEURONS - 1);
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    spike_id_d = spike_id_q;
    cnt_d      = cnt_q;
    v_we       = 1'b0;
    v_wd       = sat;
    adv        = 1'b0;
    case (state_q)
      IDLE:    if (step_i) begin
                 idx_d   = '0;
                 cnt_d   = '0;
                 state_d = FETCH;
               end
      FETCH:   state_d = UPDATE;
      UPDATE:  begin
                 v_we = 1'b1;
                 if (fire) begin
                   v_wd       = V_RESET;
                   spike_id_d = idx_q;
                   state_d    = EMIT;
                 end else adv = 1'b1;
               end
      EMIT:    if (spike_ready_i) begin
                 cnt_d = cnt_q + 1'b1;
                 adv   = 1'b1;
               end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (adv) begin
      state_d = last ? DONE : FETCH;
      idx_d   = last ? idx_q : idx_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      spike_id_q <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) v_q[i] <= V_RESET;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      spike_id_q <= spike_id_d;
      cnt_q      <= cnt_d;
      if (v_we) v_q[idx_q] <= v_wd;
    end
  end
  assign busy_o        = state_q != IDLE;
  assign done_o        = state_q == DONE;
  assign cur_rd_o      = state_q == FETCH;
  assign cur_addr_o    = idx_q;
  assign spike_valid_o = state_q == EMIT;
  assign spike_id_o    = spike_id_q;
  assign spike_count_o = cnt_q;
  assign dbg_v_o       = v_q[dbg_addr_i];
endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// tb_lif_neuron_scheduler: directed vectors; expected spike ids are queued at stimulus time and
// popped by an independent handshake monitor.
module tb_lif_neuron_scheduler;
  logic               clk = 0, rst_n = 0, step = 0, spike_ready = 0;
  logic               busy, done, cur_rd, spike_valid;
  logic [2:0]         cur_addr, spike_id, dbg_addr = 0;
  logic [3:0]         spike_count;
  logic signed [15:0] cur_data = 0, dbg_v;
  logic signed [15:0] cur_mem [8];
  int                 tests = 0, fails = 0, done_cnt = 0, rd_cnt = 0, cyc;
  int                 exp_q [$];

  lif_neuron_scheduler dut (
    .clk_i(clk), .rst_ni(rst_n), .step_i(step), .busy_o(busy), .done_o(done),
    .cur_rd_o(cur_rd), .cur_addr_o(cur_addr), .cur_data_i(cur_data),
    .spike_valid_o(spike_valid), .spike_ready_i(spike_ready), .spike_id_o(spike_id),
    .spike_count_o(spike_count), .dbg_addr_i(dbg_addr), .dbg_v_o(dbg_v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (cur_rd) cur_data <= cur_mem[cur_addr];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (cur_rd) rd_cnt++;
    if (rst_n && spike_valid && spike_ready) begin
      if (exp_q.size() == 0) chk("unexpected_spike", int'(spike_id), -1);
      else chk("spike_id", int'(spike_id), exp_q.pop_front());
    end
  end

  task automatic set_cur(input int all);
    for (int i = 0; i < 8; i++) cur_mem[i] = 16'(all);
  endtask

  task automatic chk_v(input int idx, input int exp);
    dbg_addr = 3'(idx);
    #1 chk($sformatf("v[%0d]", idx), int'(dbg_v), exp);
  endtask

  task automatic start_step();
    @(posedge clk) #1 step = 1;
    @(posedge clk) #1 step = 0;
    cyc = 0;
  endtask

  task automatic wait_done();
    do begin
      @(negedge clk) cyc++;
    end while (!done && cyc < 300);
    if (!done) chk("done_timeout", cyc, -1);
  endtask

  task automatic run_step(input int exp_cyc);
    start_step();
    wait_done();
    chk("done_cycle", cyc, exp_cyc);
    @(negedge clk) chk("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    set_cur(0);
    step = 1;
    repeat (4) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cur_rd", int'(cur_rd), 0);
    chk("rst_spike_valid", int'(spike_valid), 0);
    chk("rst_spike_id", int'(spike_id), 0);
    chk("rst_spike_count", int'(spike_count), 0);
    for (int i = 0; i < 8; i++) chk_v(i, 0);
    @(negedge clk) step = 0;
    rst_n = 1;
    spike_ready = 1;
    // integration and leak
    set_cur(50);
    run_step(17);
    for (int i = 0; i < 8; i++) chk_v(i, 50);
    chk("count_s1", int'(spike_count), 0);
    run_step(17);
    chk_v(0, 94);
    chk_v(7, 94);
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    run_step(25);
    for (int i = 0; i < 8; i++) chk_v(i, 0);
    chk("count_s3", int'(spike_count), 8);
    // threshold boundary
    set_cur(0);
    cur_mem[0] = 100;
    cur_mem[1] = 99;
    exp_q.push_back(0);
    run_step(18);
    chk_v(0, 0);
    chk_v(1, 99);
    chk("count_thr", int'(spike_count), 1);
    // backpressure on neuron 2
    set_cur(0);
    cur_mem[2] = 100;
    spike_ready = 0;
    exp_q.push_back(2);
    start_step();
    do @(negedge clk) cyc++; while (!spike_valid && cyc < 40);
    chk("bp_valid_rise_cycle", cyc, 7);
    rd_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid", int'(spike_valid), 1);
      chk("bp_id", int'(spike_id), 2);
      chk("bp_busy", int'(busy), 1);
    end
    chk("bp_no_rd", rd_cnt, 0);
    @(posedge clk) #1 spike_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_rd", int'(cur_rd), 1);
    chk("bp_next_addr", int'(cur_addr), 3);
    wait_done();
    chk_v(1, 87);
    chk_v(2, 0);
    chk("count_bp", int'(spike_count), 1);
    // saturation
    set_cur(0);
    cur_mem[0] = -32768;
    run_step(17);
    chk_v(0, -32768);
    run_step(17);
    chk_v(0, -32768);
    chk_v(1, 68);
    chk("count_sat", int'(spike_count), 0);
    // reset while a spike is pending
    cur_mem[0] = 32767;
    spike_ready = 0;
    start_step();
    do @(negedge clk) cyc++; while (!spike_valid && cyc < 40);
    chk("mid_valid", int'(spike_valid), 1);
    chk("mid_id", int'(spike_id), 0);
    rst_n = 0;
    #1 chk("mid_rst_valid", int'(spike_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    for (int i = 0; i < 8; i++) chk_v(i, 0);
    @(negedge clk) rst_n = 1;
    // step while busy
    set_cur(10);
    spike_ready = 1;
    done_cnt = 0;
    start_step();
    repeat (4) @(posedge clk);
    #1 step = 1;
    @(posedge clk) #1 step = 0;
    wait_done();
    repeat (25) @(negedge clk);
    chk("busy_step_done_cnt", done_cnt, 1);
    chk("busy_step_idle", int'(busy), 0);
    chk_v(3, 10);
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lif_neuron_scheduler.md
# lif_neuron_scheduler

Time-multiplexed leaky integrate-and-fire controller that owns the membrane state of NUM_NEURONS neurons and updates them one at a time on each timestep. On a `step` pulse it fetches each neuron's input current from an external source with one-cycle read latency, then applies leak, integration, saturation, threshold and reset. Each spike goes out as an event on a valid/ready stream. It sits between the input-current buffer and the downstream spike consumer, and it replaces per-neuron spike logic with one shared update datapath.

## Interface
- NUM_NEURONS, 8: neurons handled; ≥2.
- ADDR_W, 3: index width; 2^ADDR_W ≥ NUM_NEURONS.
- LEAK_SHIFT, 3: leak = v >>> LEAK_SHIFT (arithmetic).
- THRESHOLD, 100: signed 16-bit firing threshold; fires when v ≥ THRESHOLD.
- V_RESET, 0: signed 16-bit value loaded after a spike and on reset.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- step  input  1  timestep start pulse; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a timestep completes.
- cur_rd  output  1  current read strobe.
- cur_addr  output  ADDR_W  neuron index for the read; valid while cur_rd=1.
- cur_data  input  16 signed  input current; valid the cycle after cur_rd.
- spike_valid  output  1  spike event valid.
- spike_ready  input  1  consumer accepts the event.
- spike_id  output  ADDR_W  index of the firing neuron.
- spike_count  output  ADDR_W+1  number of spikes emitted in the current or last step.
- dbg_addr  input  ADDR_W  membrane readback index.
- dbg_v  output  16 signed  combinational readback v[dbg_addr].

## Operation
- States: IDLE, FETCH, UPDATE, EMIT, DONE.
- IDLE:
  - If step=1: idx←0, spike_count←0, go to FETCH.
  - If step=0: stay in IDLE.
- FETCH: drive cur_rd=1 and cur_addr=idx, then go to UPDATE.
- UPDATE: sample cur_data and compute in 18-bit signed arithmetic: s = v[idx] − (v[idx] >>> LEAK_SHIFT) + cur_data.
  - Saturate s to [−32768, 32767] to get sat.
  - If sat ≥ THRESHOLD: v[idx]←V_RESET, latch spike_id←idx, go to EMIT.
  - Otherwise: v[idx]←sat, then advance.
- EMIT: hold spike_valid=1 with spike_id stable until spike_ready=1.
  - On the handshake: spike_count increments, then advance.
  - spike_valid may rise before spike_ready. It must not drop before the handshake.
- Advance:
  - If idx = NUM_NEURONS−1: go to DONE.
  - Otherwise: idx+1, go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE.
- Ordering: neurons are processed strictly in ascending index. Spike events follow the same order.
- Step while busy: ignored, not queued.
- cur_rd is low in every state except FETCH. cur_addr holds idx at all times; its value is don't-care when cur_rd=0.
- spike_count holds its final value through IDLE until the next accepted step.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE, idx=0.
  - All v[i]=V_RESET.
  - busy=0, done=0, cur_rd=0, spike_valid=0, spike_id=0, spike_count=0.
  - dbg_v reflects the reset v.
- Reset mid-step aborts immediately. Any pending spike_valid drops and no partial update survives.
- Cycle timing, with the accepting step edge at edge 0:
  - FETCH of neuron i occurs in cycle 2i+1+E, where E is the number of EMIT cycles spent on earlier neurons.
  - The UPDATE write lands at the end of the following cycle.
- With no spikes, done is high in cycle 2·NUM_NEURONS+1 and busy falls one cycle later.
- Each spike adds ≥1 EMIT cycle; it adds exactly 1 if spike_ready is already high.
- spike_valid rises in the cycle after the UPDATE that fired.
- dbg_v is combinational from the register array. It shows the new v the cycle after the UPDATE write.

## Test plan
- Reset: assert rst=0 mid-idle → all outputs 0, dbg_v=0 for indices 0..7; keep step=1 during reset → no activity.
- Integration and leak, all currents 50, spike_ready=1:
  - Step 1 → dbg_v=50 for every neuron, no spikes, done pulses in cycle 17, spike_count=0.
  - Step 2 → v=94.
  - Step 3 → 94−11+50=133 ≥ 100, so 8 spikes with ids 0..7 in order, all v=0, spike_count=8.
- Threshold boundary from v=0: neuron 0 current 100, neuron 1 current 99 → neuron 0 spikes and resets to 0; neuron 1 holds 99, no spike.
- Backpressure: neuron 2 fires with spike_ready=0 for 5 cycles → spike_valid=1 and spike_id=2 held stable, no cur_rd pulses, busy=1; ready rises → handshake, then FETCH of neuron 3 follows.
- Saturation: neuron 0 current −32768 for two steps → v=−32768, then −32768+4096−32768 clamps to −32768; no wrap to positive, no spike.
- Reset mid-EMIT, and step issued while busy → on reset: spike_valid drops immediately, all v=0, state IDLE; step while busy: ignored, exactly one done per accepted step.
